// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, reset PC and field widths.
// Imported by the fetch stage and its next-PC helper.
package cpu_pkg;
  localparam int INSTR_W = 32;
  localparam int IMM_W = 16;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;

  typedef enum logic [1:0] {
    RST,
    FETCH,
    HOLD,
    FAULT
  } fetch_state_e;
endpackage

// File: rtl/if_fetch_unit_next_pc_calc.sv
// Next-PC priority mux: jr > jump > branch > sequential.
// All sums wrap modulo 2^32.
module next_pc_calc (
  input  logic [31:0] pc,
  input  logic        branch_taken,
  input  logic [31:0] branch_off32,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jr,
  input  logic [31:0] jr_target,
  output logic [31:0] pc_plus4,
  output logic [31:0] next_pc
);
  logic [31:0] br_tgt;
  logic [31:0] j_tgt;

  assign pc_plus4 = pc + 32'd4;
  assign br_tgt = pc_plus4 + (branch_off32 << 2);
  assign j_tgt = {pc_plus4[31:28], jump_index, 2'b00};

  always_comb begin
    next_pc = pc_plus4;
    if (jr) begin
      next_pc = jr_target;
    end else if (jump) begin
      next_pc = j_tgt;
    end else if (branch_taken) begin
      next_pc = br_tgt;
    end
  end
endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: PC, instruction register, RST/FETCH/HOLD FSM.
// Define IF_ALIGN_CHECK_EN to add a sticky fetch_fault for misaligned jr.
import cpu_pkg::*;

module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          ADDR_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               instr_ack,
  output logic [IMM_W-1:0]   imm16,
  input  logic               branch_taken,
  input  logic [31:0]        branch_off32,
  input  logic               jump,
  input  logic [25:0]        jump_index,
  input  logic               jr,
  input  logic [31:0]        jr_target,
`ifdef IF_ALIGN_CHECK_EN
  output logic               fetch_fault,
`endif
  output logic [ADDR_W-1:0]  pc_out,
  output logic [ADDR_W-1:0]  pc_plus4
);
  fetch_state_e       state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               valid_q, valid_d;
  logic [31:0]        jr_tgt;
  logic [31:0]        next_pc;
  logic               jr_misaligned;

`ifdef IF_ALIGN_CHECK_EN
  logic fault_q, fault_d;
  assign jr_tgt = jr_target;
  assign jr_misaligned = jr && (jr_target[1:0] != 2'b00);
  assign fetch_fault = fault_q;
`else
  assign jr_tgt = jr_target & 32'hFFFF_FFFC;
  assign jr_misaligned = 1'b0;
`endif

  next_pc_calc u_next_pc (
    .pc           (pc_q),
    .branch_taken (branch_taken),
    .branch_off32 (branch_off32),
    .jump         (jump),
    .jump_index   (jump_index),
    .jr           (jr),
    .jr_target    (jr_tgt),
    .pc_plus4     (pc_plus4),
    .next_pc      (next_pc)
  );

  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
`ifdef IF_ALIGN_CHECK_EN
    fault_d = fault_q;
`endif
    unique case (state_q)
      RST: state_d = FETCH;
      FETCH: begin
        if (imem_ready) begin
          instr_d = imem_rdata;
          valid_d = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (instr_ack) begin
          valid_d = 1'b0;
          if (jr_misaligned) begin
            state_d = FAULT;
`ifdef IF_ALIGN_CHECK_EN
            fault_d = 1'b1;
`endif
          end else begin
            pc_d = next_pc;
            state_d = FETCH;
          end
        end
      end
      FAULT: state_d = FAULT;
      default: state_d = RST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RST;
      pc_q <= RESET_PC;
      instr_q <= '0;
      valid_q <= 1'b0;
`ifdef IF_ALIGN_CHECK_EN
      fault_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
`ifdef IF_ALIGN_CHECK_EN
      fault_q <= fault_d;
`endif
    end
  end

  assign imem_req = (state_q == FETCH);
  assign imem_addr = pc_q;
  assign instr = instr_q;
  assign instr_valid = valid_q;
  assign imm16 = instr_q[IMM_W-1:0];
  assign pc_out = pc_q;
endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: vector table of redirects
// plus hand sequences for stalls, misaligned jr and reset.
module tb_if_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ack;
  logic [15:0] imm16;
  logic        branch_taken;
  logic [31:0] branch_off32;
  logic        jump;
  logic [25:0] jump_index;
  logic        jr;
  logic [31:0] jr_target;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
`ifdef IF_ALIGN_CHECK_EN
  logic        fetch_fault;
`endif

  int passed = 0;
  int total = 0;

  typedef struct {
    logic        jr;
    logic [31:0] jr_t;
    logic        jmp;
    logic [25:0] idx;
    logic        br;
    logic [31:0] off;
    logic [31:0] exp;
  } vec_t;

  vec_t tv[11];

  if_fetch_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .instr_ack    (instr_ack),
    .imm16        (imm16),
    .branch_taken (branch_taken),
    .branch_off32 (branch_off32),
    .jump         (jump),
    .jump_index   (jump_index),
    .jr           (jr),
    .jr_target    (jr_target),
`ifdef IF_ALIGN_CHECK_EN
    .fetch_fault  (fetch_fault),
`endif
    .pc_out       (pc_out),
    .pc_plus4     (pc_plus4)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  task automatic set_redir(input vec_t v);
    jr = v.jr;
    jr_target = v.jr_t;
    jump = v.jmp;
    jump_index = v.idx;
    branch_taken = v.br;
    branch_off32 = v.off;
  endtask

  task automatic clr_redir();
    jr = 0;
    jr_target = '0;
    jump = 0;
    jump_index = '0;
    branch_taken = 0;
    branch_off32 = '0;
  endtask

  logic [31:0] cur_pc;
  logic [31:0] rd;

  initial begin
    tv[0]  = '{0, 32'h0, 0, 26'h0, 0, 32'h0, 32'h0000_3008};
    tv[1]  = '{0, 32'h0, 0, 26'h0, 0, 32'h0, 32'h0000_300C};
    tv[2]  = '{0, 32'h0, 0, 26'h0, 0, 32'h0, 32'h0000_3010};
    tv[3]  = '{0, 32'h0, 0, 26'h0, 1, 32'hFFFF_FFFE, 32'h0000_300C};
    tv[4]  = '{0, 32'h0, 1, 26'h000_0C10, 0, 32'h0, 32'h0000_3040};
    tv[5]  = '{1, 32'h0040_0000, 0, 26'h0, 1, 32'h5, 32'h0040_0000};
    tv[6]  = '{0, 32'h0, 0, 26'h0, 1, 32'h1, 32'h0040_0008};
    tv[7]  = '{0, 32'h0, 1, 26'h3FF_FFFF, 1, 32'h7, 32'h0FFF_FFFC};
    tv[8]  = '{0, 32'h0, 0, 26'h0, 0, 32'h0, 32'h1000_0000};
    tv[9]  = '{1, 32'hFFFF_FFFC, 1, 26'h1, 0, 32'h0, 32'hFFFF_FFFC};
    tv[10] = '{0, 32'h0, 0, 26'h0, 0, 32'h0, 32'h0000_0000};

    rst_n = 0;
    imem_ready = 0;
    imem_rdata = '0;
    instr_ack = 0;
    clr_redir();
    step();
    step();
    chk("rst_pc", pc_out, 32'h0000_3000);
    chk("rst_req", imem_req, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instr, 0);
    rst_n = 1;
    step();
    chk("first_req", imem_req, 1);
    chk("first_addr", imem_addr, 32'h0000_3000);
    imem_ready = 1;
    imem_rdata = 32'h2008_0005;
    step();
    imem_ready = 0;
    chk("first_valid", instr_valid, 1);
    chk("first_instr", instr, 32'h2008_0005);
    chk("first_imm", imm16, 16'h0005);
    chk("first_req_lo", imem_req, 0);
    chk("first_pc4", pc_plus4, 32'h0000_3004);
    instr_ack = 1;
    step();
    instr_ack = 0;
    chk("ack_addr", imem_addr, 32'h0000_3004);
    chk("ack_req", imem_req, 1);
    chk("ack_valid", instr_valid, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_req", imem_req, 1);
      chk("stall_addr", imem_addr, 32'h0000_3004);
      chk("stall_valid", instr_valid, 0);
    end

    cur_pc = 32'h0000_3004;
    for (int i = 0; i < 11; i++) begin
      rd = {16'hC0DE, 16'(i * 3 + 1)};
      chk("tv_req", imem_req, 1);
      chk("tv_addr", imem_addr, cur_pc);
      set_redir(tv[i]);
      imem_ready = 1;
      imem_rdata = rd;
      step();
      imem_ready = 0;
      imem_rdata = '0;
      chk("tv_valid", instr_valid, 1);
      chk("tv_instr", instr, rd);
      chk("tv_imm", imm16, rd[15:0]);
      chk("tv_pc", pc_out, cur_pc);
      chk("tv_pc4", pc_plus4, cur_pc + 32'd4);
      step();
      chk("tv_hold_valid", instr_valid, 1);
      chk("tv_hold_req", imem_req, 0);
      chk("tv_hold_pc", pc_out, cur_pc);
      instr_ack = 1;
      step();
      instr_ack = 0;
      clr_redir();
      chk("tv_next_addr", imem_addr, tv[i].exp);
      chk("tv_next_valid", instr_valid, 0);
      cur_pc = tv[i].exp;
    end

    imem_ready = 1;
    imem_rdata = 32'h0BAD_0001;
    step();
    imem_ready = 0;
    jr = 1;
    branch_taken = 1;
    branch_off32 = 32'h10;
    jr_target = 32'h0040_0002;
    instr_ack = 1;
    step();
    instr_ack = 0;
    clr_redir();
`ifdef IF_ALIGN_CHECK_EN
    chk("mis_fault", fetch_fault, 1);
    chk("mis_req", imem_req, 0);
    chk("mis_pc", pc_out, 32'h0);
    imem_ready = 1;
    step();
    step();
    imem_ready = 0;
    chk("mis_fault_sticky", fetch_fault, 1);
    chk("mis_req_stuck", imem_req, 0);
    chk("mis_valid", instr_valid, 0);
`else
    chk("mis_addr", imem_addr, 32'h0040_0000);
    chk("mis_req", imem_req, 1);
`endif

    rst_n = 0;
    step();
    rst_n = 1;
    step();
    chk("rr_req", imem_req, 1);
    chk("rr_addr", imem_addr, 32'h0000_3000);
    rst_n = 0;
    imem_ready = 1;
    imem_rdata = 32'hDEAD_BEEF;
    step();
    chk("rr_valid", instr_valid, 0);
    chk("rr_instr", instr, 0);
    chk("rr_pc", pc_out, 32'h0000_3000);
    chk("rr_req_lo", imem_req, 0);
`ifdef IF_ALIGN_CHECK_EN
    chk("rr_fault", fetch_fault, 0);
`endif
    rst_n = 1;
    step();
    imem_ready = 0;
    chk("late_valid", instr_valid, 0);
    chk("late_req", imem_req, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage of the single-cycle CPU datapath; owns the PC and fetches from instruction memory over a ready handshake.
- Presents the fetched instruction and its imm16 field to decode; imm16 drives the 16→32 extender.
- Consumes the 32-bit extended offset back for branch-target computation.
- Sequential: PC register, instruction register, 3-state fetch FSM.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- ADDR_W, 32, PC/address width (only 32 supported).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- imem_req  out  1  fetch request, held until imem_ready.
- imem_addr  out  32  fetch address (= pc).
- imem_ready  in  1  imem_rdata valid this cycle; completes request.
- imem_rdata  in  32  instruction word.
- instr  out  32  registered instruction.
- instr_valid  out  1  instr/pc_out/imm16 valid.
- instr_ack  in  1  decode consumed instruction; redirect inputs sampled this cycle.
- imm16  out  16  instr[15:0], to extender.
- branch_taken  in  1  take branch.
- branch_off32  in  32  extended imm16 from extender.
- jump  in  1  J/JAL.
- jump_index  in  26  instr[25:0] target index.
- jr  in  1  register jump.
- jr_target  in  32  register value.
- pc_out  out  32  PC of instr.
- pc_plus4  out  32  pc_out + 4.

Behaviour:
- Reset (rst_n low at clk edge): pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, state=RST. Outstanding request dropped; late imem_ready ignored.
- FSM RST: next cycle → FETCH.
- FSM FETCH: imem_req=1, imem_addr=pc.
  - imem_ready=1: instr←imem_rdata, instr_valid←1 at that edge; → HOLD.
  - Otherwise stay; address stable.
- FSM HOLD: instr_valid=1, imem_req=0.
  - On instr_ack, pc←next_pc, instr_valid←0, → FETCH.
  - Without ack, hold all outputs.
- Latency/throughput: ready in first FETCH cycle + immediate ack → 2 cycles per instruction.
- next_pc priority: jr > jump > branch_taken > sequential.
  - Sequential: pc+4.
  - Branch: pc+4 + (branch_off32<<2).
  - Jump: {pc_plus4[31:28], jump_index, 2'b00}.
  - jr: jr_target.
- All adds modulo 2^32; wrap 32'hFFFF_FFFC+4 → 0. Negative offsets behave as two's complement.
- Redirect inputs ignored unless instr_valid && instr_ack.
- Multiple selects high: priority order applies, no error.
- pc_plus4 and imm16 are combinational from registered pc/instr.

Optional Feature:
- Macro IF_ALIGN_CHECK_EN.
- Defined: adds output fetch_fault (1 bit, reset 0).
  - Selected jr with jr_target[1:0]!=0 sets fetch_fault sticky.
  - pc is not updated; FSM enters FAULT, imem_req=0; only reset exits.
- Undefined: jr_target[1:0] forced to 2'b00, no fault port.

Decomposition:
- Shared package cpu_pkg: fetch state enum (RST, FETCH, HOLD, FAULT), RESET_PC default, INSTR_W=32, IMM_W=16.
- One sub-module next_pc_calc: combinational priority mux and adders for next_pc.

Test Plan:
- Reset → pc_out=32'h3000, imem_req=1 cycle after reset release.
  - imem_ready with rdata 32'h2008_0005 → instr_valid=1, imm16=16'h0005.
  - ack → next imem_addr=32'h3004.
- imem_ready low 3 cycles → imem_req and imem_addr held at 32'h3004; instr_valid stays 0.
- pc=32'h3010, branch_taken, branch_off32=32'hFFFF_FFFE on ack → next imem_addr=32'h300C.
- pc=32'h3000, jump, jump_index=26'h000_0C10 → imem_addr=32'h0000_3040.
- jr and branch both high, jr_target=32'h0040_0000 → imem_addr=32'h0040_0000.
  - Repeat with jr_target=32'h0040_0002: IF_ALIGN_CHECK_EN → fetch_fault=1, no request; otherwise → imem_addr=32'h0040_0000.
- rst_n low during FETCH with imem_ready arriving the same cycle → instr_valid=0, pc=RESET_PC, instruction discarded.
